// File: rtl/mips_ctrl_pkg.sv
// Control-bus codes shared by the ALU control sequencer, the ALU and the
// multiplier.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_FIRST   = 6'b111110;
    localparam logic [5:0] OP_MULTU   = 6'b011001;
    localparam logic [5:0] OP_HILO_WR = 6'b111111;
    localparam logic [5:0] OP_MFHI    = 6'b010000;
    localparam logic [5:0] OP_MFLO    = 6'b010010;

    localparam logic [5:0] OP_AND     = 6'b100100;
    localparam logic [5:0] OP_OR      = 6'b100101;
    localparam logic [5:0] OP_ADD     = 6'b100000;
    localparam logic [5:0] OP_SUB     = 6'b100010;
    localparam logic [5:0] OP_SLT     = 6'b101010;
    localparam logic [5:0] OP_SLL     = 6'b000000;

endpackage

// File: rtl/multu_step.sv
// One shift-add step of the unsigned multiplier: conditional add of the
// multiplicand into the upper half, then shift right with the carry entering at the top.
module multu_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] prod,
    input  logic [WIDTH-1:0]   mcand,
    output logic [2*WIDTH-1:0] prod_next
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum = {1'b0, prod[2*WIDTH-1:WIDTH]};
        if (prod[0]) begin
            sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
        end
        prod_next = {sum, prod[WIDTH-1:1]};
    end

endmodule

// File: rtl/multu_hilo.sv
// Sequential unsigned multiplier with HI/LO result registers, driven one
// control code per cycle from the shared control bus.
module multu_hilo
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Signal,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic [WIDTH-1:0] dataOut,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int unsigned SW = $clog2(WIDTH) + 1;
    localparam logic [SW-1:0] STEP_MAX = SW'(WIDTH);

    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [2*WIDTH-1:0] prod;
    logic [SW-1:0]      step;

    logic               is_first;
    logic [2*WIDTH-1:0] step_in;
    logic [WIDTH-1:0]   mcand_in;
    logic [2*WIDTH-1:0] step_out;

    // FIRST feeds the step directly from the operand inputs so the first
    // product bit is consumed in the same cycle the operands are captured.
    always_comb begin
        is_first = (Signal == OP_FIRST);
        step_in  = is_first ? {{WIDTH{1'b0}}, dataB} : prod;
        mcand_in = is_first ? dataA : mcand;
    end

    multu_step #(.WIDTH(WIDTH)) u_step (
        .prod      (step_in),
        .mcand     (mcand_in),
        .prod_next (step_out)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand   <= '0;
            prod    <= '0;
            step    <= '0;
            hi      <= '0;
            lo      <= '0;
            dataOut <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (Signal)
                OP_FIRST: begin
                    mcand <= dataA;
                    prod  <= step_out;
                    step  <= SW'(1);
                    busy  <= 1'b1;
                    err   <= 1'b0;
                end
                OP_MULTU: begin
                    if (busy && (step < STEP_MAX)) begin
                        prod <= step_out;
                        step <= step + SW'(1);
                    end
                end
                OP_HILO_WR: begin
                    if (busy) begin
                        if (step == STEP_MAX) begin
                            hi   <= prod[2*WIDTH-1:WIDTH];
                            lo   <= prod[WIDTH-1:0];
                            done <= 1'b1;
                        end else begin
                            err  <= 1'b1;
                        end
                        busy <= 1'b0;
                    end
                end
                OP_MFHI: dataOut <= hi;
                OP_MFLO: dataOut <= lo;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multu_hilo.sv
// Directed self-checking bench for multu_hilo.
module tb_multu_hilo;
    import mips_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  Signal;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [31:0] dataOut;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int fails  = 0;

    multu_hilo #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .Signal  (Signal),
        .dataA   (dataA),
        .dataB   (dataB),
        .dataOut (dataOut),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    // Drive a code at the falling edge; return just after the rising edge.
    task automatic drive(input logic [5:0] code, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        Signal = code;
        dataA  = a;
        dataB  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [5:0] code);
        drive(code, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    endtask

    task automatic multus(input int n);
        for (int i = 0; i < n; i++) op(OP_MULTU);
    endtask

    task automatic test_reset;
        reset  = 1'b1;
        Signal = OP_ADD;
        dataA  = '0;
        dataB  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (dataOut !== 32'h0) begin fails++; $display("FAIL reset_dataOut: got %h want 0", dataOut); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", err); end
        op(OP_MFHI);
        checks++; if (dataOut !== 32'h0) begin fails++; $display("FAIL reset_hi: got %h want 0", dataOut); end
    endtask

    task automatic test_small;
        drive(OP_FIRST, 32'd3, 32'd5);
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL small_busy: got %b want 1", busy); end
        multus(31);
        checks++; if (done !== 1'b0) begin fails++; $display("FAIL small_done_early: got %b want 0", done); end
        op(OP_HILO_WR);
        checks++; if (done !== 1'b1) begin fails++; $display("FAIL small_done: got %b want 1", done); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL small_busy_clr: got %b want 0", busy); end
        checks++; if (err !== 1'b0) begin fails++; $display("FAIL small_err: got %b want 0", err); end
        op(OP_MFLO);
        checks++; if (dataOut !== 32'd15) begin fails++; $display("FAIL small_lo: got %h want f", dataOut); end
        checks++; if (done !== 1'b0) begin fails++; $display("FAIL small_done_pulse: got %b want 0", done); end
        op(OP_MFHI);
        checks++; if (dataOut !== 32'd0) begin fails++; $display("FAIL small_hi: got %h want 0", dataOut); end
    endtask

    task automatic test_max;
        drive(OP_FIRST, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        multus(31);
        op(OP_HILO_WR);
        checks++; if (done !== 1'b1) begin fails++; $display("FAIL max_done: got %b want 1", done); end
        op(OP_MFHI);
        checks++; if (dataOut !== 32'hFFFF_FFFE) begin fails++; $display("FAIL max_hi: got %h want fffffffe", dataOut); end
        op(OP_MFLO);
        checks++; if (dataOut !== 32'h0000_0001) begin fails++; $display("FAIL max_lo: got %h want 00000001", dataOut); end
    endtask

    task automatic test_interleave;
        drive(OP_FIRST, 32'h1234_5678, 32'h9ABC_DEF0);
        multus(12);
        for (int i = 0; i < 5; i++) op(OP_ADD);
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL stall_busy: got %b want 1", busy); end
        op(OP_MFHI);
        checks++; if (dataOut !== 32'hFFFF_FFFE) begin fails++; $display("FAIL stall_old_hi: got %h want fffffffe", dataOut); end
        multus(19);
        op(OP_HILO_WR);
        checks++; if (err !== 1'b0) begin fails++; $display("FAIL stall_err: got %b want 0", err); end
        op(OP_MFHI);
        checks++; if (dataOut !== 32'h0B00_EA4E) begin fails++; $display("FAIL stall_hi: got %h want 0b00ea4e", dataOut); end
        op(OP_MFLO);
        checks++; if (dataOut !== 32'h242D_2080) begin fails++; $display("FAIL stall_lo: got %h want 242d2080", dataOut); end
    endtask

    task automatic test_short;
        drive(OP_FIRST, 32'd7, 32'd9);
        multus(10);
        op(OP_HILO_WR);
        checks++; if (err !== 1'b1) begin fails++; $display("FAIL short_err: got %b want 1", err); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL short_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin fails++; $display("FAIL short_done: got %b want 0", done); end
        op(OP_MFLO);
        checks++; if (dataOut !== 32'h242D_2080) begin fails++; $display("FAIL short_lo: got %h want 242d2080", dataOut); end
        op(OP_MFHI);
        checks++; if (dataOut !== 32'h0B00_EA4E) begin fails++; $display("FAIL short_hi: got %h want 0b00ea4e", dataOut); end
        checks++; if (err !== 1'b1) begin fails++; $display("FAIL short_err_sticky: got %b want 1", err); end
        op(OP_HILO_WR);
        checks++; if (err !== 1'b1) begin fails++; $display("FAIL short_idle_wr: got %b want 1", err); end
    endtask

    task automatic test_back_to_back;
        drive(OP_FIRST, 32'd2, 32'd2);
        checks++; if (err !== 1'b0) begin fails++; $display("FAIL restart_err_clr: got %b want 0", err); end
        multus(15);
        drive(OP_FIRST, 32'd6, 32'd7);
        multus(31);
        multus(3);
        op(OP_HILO_WR);
        checks++; if (done !== 1'b1) begin fails++; $display("FAIL restart_done: got %b want 1", done); end
        op(OP_MFLO);
        checks++; if (dataOut !== 32'd42) begin fails++; $display("FAIL restart_lo: got %h want 2a", dataOut); end
        op(OP_MFHI);
        checks++; if (dataOut !== 32'd0) begin fails++; $display("FAIL restart_hi: got %h want 0", dataOut); end
    endtask

    task automatic test_async_reset;
        drive(OP_FIRST, 32'd3, 32'd5);
        multus(20);
        op(OP_MFLO);
        checks++; if (dataOut !== 32'd42) begin fails++; $display("FAIL areset_pre: got %h want 2a", dataOut); end
        @(negedge clk);
        Signal = OP_ADD;
        #2 reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL areset_busy: got %b want 0", busy); end
        checks++; if (dataOut !== 32'd0) begin fails++; $display("FAIL areset_dataOut: got %h want 0", dataOut); end
        checks++; if (done !== 1'b0 || err !== 1'b0) begin fails++; $display("FAIL areset_flags: got done=%b err=%b want 0", done, err); end
        @(negedge clk);
        reset = 1'b0;
        op(OP_MFLO);
        checks++; if (dataOut !== 32'd0) begin fails++; $display("FAIL areset_lo: got %h want 0", dataOut); end
        op(OP_HILO_WR);
        checks++; if (done !== 1'b0) begin fails++; $display("FAIL areset_no_commit: got %b want 0", done); end
    endtask

    initial begin
        test_reset;
        test_small;
        test_max;
        test_interleave;
        test_short;
        test_back_to_back;
        test_async_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/multu_hilo.md
# multu_hilo

Sequential 32-bit unsigned shift-add multiplier with HI/LO result registers. It consumes the 6-bit control codes issued on the shared control bus (`SignaltoMUL`) and produces one product bit-step per clock. It commits the 64-bit product to HI/LO on the HiLo-write code and returns HI or LO on MFHI/MFLO. It is the datapath responder to the ALU control sequencer's MULTU sequence.

## Interface
- `WIDTH`, 32, operand width; product is 2*WIDTH.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `Signal`  in  6  control code from the ALU control sequencer.
- `dataA`  in  WIDTH  multiplicand; sampled only on FIRST.
- `dataB`  in  WIDTH  multiplier; sampled only on FIRST.
- `dataOut`  out  WIDTH  registered HI/LO read data.
- `busy`  out  1  multiply in progress, from FIRST until the HiLo-write code.
- `done`  out  1  one-cycle pulse after a successful HI/LO commit.
- `err`  out  1  sticky; HiLo-write arrived with step count ≠ WIDTH; cleared by FIRST or reset.

## Operation
- Codes:
  - FIRST = 6'b111110
  - MULTU = 6'b011001
  - HILO_WR = 6'b111111
  - MFHI = 6'b010000
  - MFLO = 6'b010010
  - all other codes: no action (state holds).
- Internal state:
  - `mcand[WIDTH-1:0]`
  - `prod[2*WIDTH-1:0]`
  - `step[$clog2(WIDTH):0]`
  - `hi`, `lo`.
- Step function, shared by FIRST and MULTU:
  - If `prod[0]`: `sum = {1'b0, prod[2W-1:W]} + {1'b0, mcand}` (W+1 bits); else `sum = {1'b0, prod[2W-1:W]}`.
  - Next `prod = {sum, prod[W-1:1]}` (the carry shifts in at the top).
- FIRST:
  - Set `mcand = dataA`.
  - Apply the step to the seed `{W'b0, dataB}`. This uses `dataB[0]` directly.
  - Set `step = 1`, `busy = 1`, `err = 0`.
  - FIRST restarts unconditionally, even mid-operation.
- MULTU:
  - If `busy && step < WIDTH`: apply the step and increment `step`.
  - Otherwise ignore; `step` saturates at WIDTH.
- HILO_WR:
  - If `busy && step == WIDTH`: `hi = prod[2W-1:W]`, `lo = prod[W-1:0]`, then `done` pulses.
  - If `busy && step != WIDTH`: HI/LO unchanged and `err = 1`.
  - In both busy cases, `busy` clears.
  - If not busy: ignored.
- MFHI / MFLO: `dataOut` loads `hi` / `lo` respectively.
- Protocol sequence: one FIRST, then 31 MULTU, then HILO_WR. This totals 32 steps for WIDTH = 32.

## Timing
- Reset values: `dataOut = 0`, `busy = 0`, `done = 0`, `err = 0`; `hi`, `lo`, `prod`, `mcand`, `step` all 0.
- Reset mid-operation aborts the multiply; HI/LO return to 0.
- With FIRST sampled at edge 0:
  - MULTU is sampled at edges 1..31.
  - HILO_WR is sampled at edge 32.
  - HI/LO are valid after edge 32; `done = 1` for the cycle following edge 32.
  - An MFLO sampled at edge 33 gives `dataOut = lo` after edge 33.
- Read latency: 1 clock, Signal to `dataOut`.
- Non-multiply codes between steps stall the multiply without loss. `busy` stays high.
- MFHI/MFLO during `busy` return the previous HI/LO.
- Only one code per cycle, so there are no simultaneous-code cases. FIRST always has priority by definition.

## Structure
- Package `mips_ctrl_pkg`: the 6-bit opcode constants above, plus the ALU codes AND/OR/ADD/SUB/SLT/SLL, shared with the sequencer and the ALU.
- Sub-module `multu_step`: combinational one-step shift-add, with `(prod, mcand)` in and the next `prod` out. It is used by both the FIRST and MULTU paths.

## Test plan
- A=3, B=5, full sequence (FIRST, 31×MULTU, HILO_WR, MFLO, MFHI) -> LO = 15, HI = 0, `done` one cycle, `err` = 0.
- A=B=32'hFFFFFFFF, full sequence -> HI = 32'hFFFFFFFE, LO = 32'h00000001.
- A=32'h12345678, B=32'h9ABCDEF0, with 5 ADD codes interleaved mid-sequence -> product unchanged: HI = 32'h0B00EA4E, LO = 32'h242D2080.
- FIRST (A=7, B=9), then 10 MULTU, then HILO_WR -> `err` = 1, HI/LO keep their prior values, `busy` = 0.
- FIRST (A=2, B=2), 15 MULTU, then new FIRST (A=6, B=7) and a full sequence -> LO = 42.
- Reset asserted asynchronously after 20 MULTU -> `busy`, `done`, `err`, `dataOut` = 0 immediately; MFLO after release returns 0.
